commit_trace_gen: RTL and testbench

//  Producer side of the processor commit-trace interface consumed by the bench monitor.

---
 rtl/proc_trace_pkg.sv | 24 ++
 rtl/trace_fifo.sv | 51 +++++
 rtl/commit_trace_gen.sv | 173 +++++++++++++++++
 tb/tb_commit_trace_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_trace_pkg.sv
// Shared types for the processor commit-trace producer: record layout,
// counter width and FSM state encodings.
package proc_trace_pkg;

    localparam int TRACE_CW = 32;

    // One instruction's MEM-stage view, held until it retires in WB.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        halt;
    } trace_rec_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular buffer of in-flight MEM records. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate count.
module trace_fifo
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  trace_rec_t pushRec,
    input  logic       pop,
    output trace_rec_t popRec,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    trace_rec_t  store [DEPTH];
    logic        doPush;
    logic        doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    // A full buffer still accepts a push when a pop frees the head slot in the same cycle.
    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;
    assign popRec = store[rdPtr[AW-1:0]];

    // Pointer update; the extra MSB makes the wrap modulo DEPTH implicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    // Record storage write port.
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush) store[wrPtr[AW-1:0]] <= pushRec;
    end

endmodule

// File: rtl/commit_trace_gen.sv
// Commit-trace producer: pairs MEM records with WB retirements, emits one
// registered commit record per retired instruction, keeps saturating event
// counters and a sticky halted flag.
module commit_trace_gen
    import proc_trace_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = TRACE_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [15:0]   mem_pc,
    input  logic [15:0]   mem_inst,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [15:0]   mem_addr,
    input  logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_halt,
    input  logic          wb_valid,
    input  logic          wb_reg_wr,
    input  logic [2:0]    wb_reg,
    input  logic [15:0]   wb_data,
    input  logic          icache_req,
    input  logic          icache_hit,
    input  logic          dcache_req,
    input  logic          dcache_hit,
    output logic          cm_valid,
    output logic [15:0]   cm_pc,
    output logic [15:0]   cm_inst,
    output logic [15:0]   cm_mem_addr,
    output logic [15:0]   cm_mem_wdata,
    output logic [15:0]   cm_mem_rdata,
    output logic          cm_reg_wr,
    output logic          cm_mem_rd,
    output logic          cm_mem_wr,
    output logic          cm_halt,
    output logic [2:0]    cm_reg,
    output logic [15:0]   cm_reg_data,
    output logic          halted,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] inst_count,
    output logic [CW-1:0] icache_req_cnt,
    output logic [CW-1:0] icache_hit_cnt,
    output logic [CW-1:0] dcache_req_cnt,
    output logic [CW-1:0] dcache_hit_cnt,
    output logic          err_ovf,
    output logic          err_udf
);

    trace_state_t state;
    trace_state_t nextState;
    logic         pushReq;
    logic         popReq;
    logic         popOk;
    logic         fifoFull;
    logic         fifoEmpty;
    trace_rec_t   memRec;
    trace_rec_t   headRec;
    logic         running;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign memRec = '{pc: mem_pc, inst: mem_inst, rd: mem_rd, wr: mem_wr,
                      addr: mem_addr, wdata: mem_wdata, rdata: mem_rdata,
                      halt: mem_halt};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (pushReq),
        .pushRec (memRec),
        .pop     (popReq),
        .popRec  (headRec),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    assign popOk   = popReq && !fifoEmpty;
    assign running = (state == RUN);
    assign halted  = (state == HALTED);

    // FSM state register; HALTED is left only through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= nextState;
    end

    // Next state and buffer handshakes; inputs are ignored once halted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        nextState = state;
        pushReq   = 1'b0;
        popReq    = 1'b0;
        case (state)
            RUN: begin
                pushReq = mem_valid;
                popReq  = wb_valid;
                if (wb_valid && !fifoEmpty && headRec.halt) nextState = HALTED;
            end
            HALTED: ;
            default: nextState = RUN;
        endcase
    end

    // Commit record register: pulse valid, data fields hold between commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_valid     <= 1'b0;
            cm_pc        <= '0;
            cm_inst      <= '0;
            cm_mem_addr  <= '0;
            cm_mem_wdata <= '0;
            cm_mem_rdata <= '0;
            cm_reg_wr    <= 1'b0;
            cm_mem_rd    <= 1'b0;
            cm_mem_wr    <= 1'b0;
            cm_halt      <= 1'b0;
            cm_reg       <= '0;
            cm_reg_data  <= '0;
        end else begin
            cm_valid <= popOk;
            if (popOk) begin
                cm_pc        <= headRec.pc;
                cm_inst      <= headRec.inst;
                cm_mem_addr  <= headRec.addr;
                cm_mem_wdata <= headRec.wdata;
                cm_mem_rdata <= headRec.rdata;
                cm_mem_rd    <= headRec.rd;
                cm_mem_wr    <= headRec.wr;
                cm_halt      <= headRec.halt;
                cm_reg_wr    <= wb_reg_wr;
                cm_reg       <= wb_reg;
                cm_reg_data  <= wb_data;
            end
        end
    end

    // Sticky protocol errors: push into a full buffer without a pop, pop from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (pushReq && fifoFull && !popReq) err_ovf <= 1'b1;
            if (popReq && fifoEmpty)            err_udf <= 1'b1;
        end
    end

    // Saturating event counters, frozen once halted (the halting edge still counts).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count    <= '0;
            inst_count     <= '0;
            icache_req_cnt <= '0;
            icache_hit_cnt <= '0;
            dcache_req_cnt <= '0;
            dcache_hit_cnt <= '0;
        end else if (running) begin
            cycle_count <= satInc(cycle_count);
            if (popOk && (headRec.halt || wb_reg_wr || headRec.wr))
                inst_count <= satInc(inst_count);
            if (icache_req) icache_req_cnt <= satInc(icache_req_cnt);
            if (icache_hit) icache_hit_cnt <= satInc(icache_hit_cnt);
            if (dcache_req) dcache_req_cnt <= satInc(dcache_req_cnt);
            if (dcache_hit) dcache_hit_cnt <= satInc(dcache_hit_cnt);
        end
    end

endmodule

// File: tb/tb_commit_trace_gen.sv
// Directed bench for commit_trace_gen: reset, ALU, store/load, fill/overflow,
// halt freeze, and counter saturation on a narrow-counter instance.
module tb_commit_trace_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid, mem_rd, mem_wr, mem_halt;
    logic [15:0] mem_pc, mem_inst, mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid, wb_reg_wr;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;

    logic        cm_valid, cm_reg_wr, cm_mem_rd, cm_mem_wr, cm_halt, halted, err_ovf, err_udf;
    logic [15:0] cm_pc, cm_inst, cm_mem_addr, cm_mem_wdata, cm_mem_rdata, cm_reg_data;
    logic [2:0]  cm_reg;
    logic [31:0] cycle_count, inst_count, icache_req_cnt, icache_hit_cnt, dcache_req_cnt, dcache_hit_cnt;

    logic        sCmValid, sCmRegWr, sCmMemRd, sCmMemWr, sCmHalt, sHalted, sErrOvf, sErrUdf;
    logic [15:0] sCmPc, sCmInst, sCmMemAddr, sCmMemWdata, sCmMemRdata, sCmRegData;
    logic [2:0]  sCmReg;
    logic [3:0]  sCycleCount, sInstCount, sIcReq, sIcHit, sDcReq, sDcHit;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always #5 clk = ~clk;

    commit_trace_gen #(.DEPTH(4), .CW(32)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_inst(mem_inst),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_halt(mem_halt),
        .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_reg(wb_reg), .wb_data(wb_data),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_mem_addr(cm_mem_addr), .cm_mem_wdata(cm_mem_wdata), .cm_mem_rdata(cm_mem_rdata),
        .cm_reg_wr(cm_reg_wr), .cm_mem_rd(cm_mem_rd), .cm_mem_wr(cm_mem_wr),
        .cm_halt(cm_halt), .cm_reg(cm_reg), .cm_reg_data(cm_reg_data),
        .halted(halted), .cycle_count(cycle_count), .inst_count(inst_count),
        .icache_req_cnt(icache_req_cnt), .icache_hit_cnt(icache_hit_cnt),
        .dcache_req_cnt(dcache_req_cnt), .dcache_hit_cnt(dcache_hit_cnt),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    commit_trace_gen #(.DEPTH(4), .CW(4)) dutSmall (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_inst(mem_inst),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_halt(mem_halt),
        .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_reg(wb_reg), .wb_data(wb_data),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .cm_valid(sCmValid), .cm_pc(sCmPc), .cm_inst(sCmInst),
        .cm_mem_addr(sCmMemAddr), .cm_mem_wdata(sCmMemWdata), .cm_mem_rdata(sCmMemRdata),
        .cm_reg_wr(sCmRegWr), .cm_mem_rd(sCmMemRd), .cm_mem_wr(sCmMemWr),
        .cm_halt(sCmHalt), .cm_reg(sCmReg), .cm_reg_data(sCmRegData),
        .halted(sHalted), .cycle_count(sCycleCount), .inst_count(sInstCount),
        .icache_req_cnt(sIcReq), .icache_hit_cnt(sIcHit),
        .dcache_req_cnt(sDcReq), .dcache_hit_cnt(sDcHit),
        .err_ovf(sErrOvf), .err_udf(sErrUdf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        mem_valid = 0; mem_pc = '0; mem_inst = '0; mem_rd = 0; mem_wr = 0;
        mem_addr = '0; mem_wdata = '0; mem_rdata = '0; mem_halt = 0;
        wb_valid = 0; wb_reg_wr = 0; wb_reg = '0; wb_data = '0;
        icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        @(posedge clk);
        #4;
        rst = 1'b0;
        edges = 0;
    endtask

    task automatic setPush(input logic [15:0] pc, input logic [15:0] inst, input logic rd,
                           input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input logic halt);
        mem_valid = 1; mem_pc = pc; mem_inst = inst; mem_rd = rd; mem_wr = wr;
        mem_addr = addr; mem_wdata = wdata; mem_rdata = rdata; mem_halt = halt;
    endtask

    task automatic setPop(input logic regWr, input logic [2:0] rg, input logic [15:0] data);
        wb_valid = 1; wb_reg_wr = regWr; wb_reg = rg; wb_data = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clearInputs();
        doReset();

        // 1: reset mid-stream with two records buffered.
        setPush(16'h0030, 16'h1111, 0, 0, 0, 0, 0, 0); step();
        setPush(16'h0032, 16'h2222, 0, 0, 0, 0, 0, 0); step();
        setPush(16'h0034, 16'h3333, 0, 0, 0, 0, 0, 0);
        setPop(1, 3'd4, 16'h00AA); step();
        check("t1_pre_valid", cm_valid, 1);
        check("t1_pre_pc", cm_pc, 16'h0030);
        check("t1_pre_inst", inst_count, 1);
        clearInputs();
        #2 rst = 1'b1;
        #1;
        check("t1_rst_valid", cm_valid, 0);
        check("t1_rst_pc", cm_pc, 0);
        check("t1_rst_regdata", cm_reg_data, 0);
        check("t1_rst_cycle", cycle_count, 0);
        check("t1_rst_inst", inst_count, 0);
        check("t1_rst_halted", halted, 0);
        #1 rst = 1'b0;
        edges = 0;
        setPop(1, 3'd1, 16'h0001); step();
        check("t1_udf", err_udf, 1);
        check("t1_udf_nocommit", cm_valid, 0);
        check("t1_udf_ovf", err_ovf, 0);

        // 2: single ALU instruction.
        doReset();
        setPush(16'h0002, 16'hC105, 0, 0, 0, 0, 0, 0); step();
        clearInputs();
        setPop(1, 3'd1, 16'h0005); step();
        check("t2_valid", cm_valid, 1);
        check("t2_pc", cm_pc, 16'h0002);
        check("t2_inst", cm_inst, 16'hC105);
        check("t2_reg", cm_reg, 1);
        check("t2_regwr", cm_reg_wr, 1);
        check("t2_data", cm_reg_data, 16'h0005);
        check("t2_icount", inst_count, 1);
        check("t2_cycle", cycle_count, 2);
        clearInputs(); step();
        check("t2_pulse", cm_valid, 0);
        check("t2_hold", cm_reg_data, 16'h0005);

        // 3: store then load two cycles apart.
        doReset();
        setPush(16'h0010, 16'h7010, 0, 1, 16'h0010, 16'hBEEF, 0, 0); step();
        clearInputs(); step();
        setPush(16'h0014, 16'h6010, 1, 0, 16'h0010, 0, 16'hBEEF, 0); step();
        clearInputs();
        setPop(0, 3'd0, 16'h0000); step();
        check("t3_st_pc", cm_pc, 16'h0010);
        check("t3_st_wr", cm_mem_wr, 1);
        check("t3_st_rd", cm_mem_rd, 0);
        check("t3_st_addr", cm_mem_addr, 16'h0010);
        check("t3_st_wdata", cm_mem_wdata, 16'hBEEF);
        check("t3_st_icount", inst_count, 1);
        setPop(1, 3'd2, 16'hBEEF); step();
        check("t3_ld_pc", cm_pc, 16'h0014);
        check("t3_ld_rd", cm_mem_rd, 1);
        check("t3_ld_wr", cm_mem_wr, 0);
        check("t3_ld_rdata", cm_mem_rdata, 16'hBEEF);
        check("t3_ld_reg", cm_reg, 2);
        check("t3_ld_icount", inst_count, 2);

        // 4: fill, push+pop while full, overflow, drain in order.
        doReset();
        for (int i = 0; i < 4; i++) begin
            setPush(16'h0100 + 16'(i), 16'h0, 0, 0, 0, 0, 0, 0); step();
        end
        check("t4_full_noovf", err_ovf, 0);
        setPush(16'h0104, 16'h0, 0, 0, 0, 0, 0, 0);
        setPop(1, 3'd3, 16'h0000); step();
        check("t4_pp_pc", cm_pc, 16'h0100);
        check("t4_pp_noovf", err_ovf, 0);
        clearInputs();
        setPush(16'h0105, 16'h0, 0, 0, 0, 0, 0, 0); step();
        check("t4_ovf", err_ovf, 1);
        check("t4_ovf_nocommit", cm_valid, 0);
        clearInputs();
        for (int i = 0; i < 4; i++) begin
            setPop(1, 3'd3, 16'h0000); step();
            check("t4_drain_valid", cm_valid, 1);
            check("t4_drain_pc", cm_pc, 16'h0101 + 16'(i));
        end
        check("t4_no_udf", err_udf, 0);
        step();
        check("t4_lost", err_udf, 1);

        // 5: halt commit and freeze.
        doReset();
        icache_req = 1;
        setPush(16'h0020, 16'h1234, 0, 0, 0, 0, 0, 0); step();
        setPush(16'h0022, 16'hF000, 0, 0, 0, 0, 0, 1);
        setPop(1, 3'd5, 16'h0042); step();
        check("t5_alu_pc", cm_pc, 16'h0020);
        check("t5_not_halted", halted, 0);
        setPush(16'h0024, 16'h1111, 0, 0, 0, 0, 0, 0);
        setPop(0, 3'd0, 16'h0000); step();
        check("t5_halt_valid", cm_valid, 1);
        check("t5_cm_halt", cm_halt, 1);
        check("t5_halted", halted, 1);
        check("t5_icount", inst_count, 2);
        check("t5_cycle", cycle_count, edges);
        check("t5_icreq", icache_req_cnt, 3);
        setPop(1, 3'd1, 16'h0001);
        dcache_req = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_frozen_valid", cm_valid, 0);
        end
        check("t5_frozen_cycle", cycle_count, 3);
        check("t5_frozen_icreq", icache_req_cnt, 3);
        check("t5_frozen_dcreq", dcache_req_cnt, 0);
        check("t5_frozen_icount", inst_count, 2);
        check("t5_frozen_pc", cm_pc, 16'h0022);
        check("t5_still_halted", halted, 1);
        check("t5_no_ovf", err_ovf, 0);

        // 6: saturation of a 4-bit counter instance.
        doReset();
        icache_hit = 1;
        for (int i = 0; i < 20; i++) step();
        clearInputs();
        check("t6_small_ichit", sIcHit, 15);
        check("t6_small_cycle", sCycleCount, 15);
        check("t6_small_icreq", sIcReq, 0);
        check("t6_wide_ichit", icache_hit_cnt, 20);
        check("t6_wide_cycle", cycle_count, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
